// File: rtl/mips_pkg.sv
// Types and widths shared by the MIPS pipeline stages: MEM-stage FSM state
// and the MEM/WB register bundle.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memState_t;

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memToReg;
        logic [WORD_W-1:0]     readData;
        logic [WORD_W-1:0]     result;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     ir;
        logic [REG_ADDR_W-1:0] regDest;
    } memWb_t;

    // A load and a store flagged together are treated as a store.
    function automatic logic isMemOp(input logic valid, input logic memRead, input logic memWrite);
        return valid & (memRead | memWrite);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the
// variable-latency data memory (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for a data-memory access; raises timeoutHit
// once TIMEOUT waiting cycles have elapsed (TIMEOUT = 0 disables it).
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeoutHit
);

    localparam int              CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeoutHit = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory handshake, upstream
// stall, branch/jump redirect and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: reject misaligned accesses with oErr.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  iValid,
    input  logic                  iRegWrite,
    input  logic                  iMemRead,
    input  logic                  iMemWrite,
    input  logic                  iMemToReg,
    input  logic                  iBranchs,
    input  logic                  iJumps,
    input  logic                  iZero,
    input  logic [WORD_W-1:0]     iResult,
    input  logic [WORD_W-1:0]     iB,
    input  logic [REG_ADDR_W-1:0] iRegDest,
    input  logic [WORD_W-1:0]     iBranch,
    input  logic [WORD_W-1:0]     iJump,
    input  logic [WORD_W-1:0]     iPC,
    input  logic [WORD_W-1:0]     iIR,

    output logic                  stall,
    output logic                  pc_redirect,
    output logic [WORD_W-1:0]     pc_target,

    mem_access_stage_if.master    dmem,

    output logic                  oValid,
    output logic                  oRegWrite,
    output logic                  oMemToReg,
    output logic [WORD_W-1:0]     oReadData,
    output logic [WORD_W-1:0]     oResult,
    output logic [WORD_W-1:0]     oPC,
    output logic [WORD_W-1:0]     oIR,
    output logic [REG_ADDR_W-1:0] oRegDest,
    output logic                  oErr
);

    memState_t         state;
    memWb_t            memWb;
    memWb_t            pending;
    memWb_t            inBundle;
    logic              memop;
    logic              misaligned;
    logic              issue;
    logic              timeoutHit;
    logic [ADDR_W-1:0] reqAddr;

    assign memop = isMemOp(iValid, iMemRead, iMemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memop & (iResult[1:0] != 2'b00);
    assign reqAddr    = iResult[ADDR_W-1:0];
`else
    assign misaligned = 1'b0;
    assign reqAddr    = {iResult[ADDR_W-1:2], 2'b00};
`endif

    assign issue = memop & !misaligned;

    // Combinational so EX/MEM advances on the very edge the access completes.
    assign stall = ((state == IDLE) & issue)
                 | ((state == ACCESS) & !dmem.dmem_ready & !timeoutHit);

    assign pc_redirect = iValid & (state == IDLE) & (iJumps | (iBranchs & iZero));
    assign pc_target   = iJumps ? iJump : iBranch;

    // NOTE: every field gets a value on every path, so no latch is inferred.
    always_comb begin
        inBundle          = '0;
        inBundle.valid    = iValid;
        inBundle.regWrite = iRegWrite & !iMemWrite & !misaligned;
        inBundle.memToReg = iMemToReg;
        inBundle.readData = memWb.readData;
        inBundle.result   = iResult;
        inBundle.pc       = iPC;
        inBundle.ir       = iIR;
        inBundle.regDest  = iRegDest;
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_waitTimer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (state == IDLE),
        .enable     ((state == ACCESS) & !dmem.dmem_ready),
        .timeoutHit (timeoutHit)
    );

    // Access FSM; request signals stay frozen for the whole ACCESS phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            pending         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state           <= ACCESS;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= iMemWrite;
                        dmem.dmem_addr  <= reqAddr;
                        dmem.dmem_wdata <= iB;
                        pending         <= inBundle;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ready || timeoutHit) begin
                        state         <= IDLE;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register; ready beats a same-cycle timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memWb <= '0;
            oErr  <= 1'b0;
        end else begin
            oErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        memWb.valid <= 1'b0;
                    end else begin
                        memWb <= inBundle;
                        oErr  <= misaligned;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ready) begin
                        memWb          <= pending;
                        memWb.readData <= dmem.dmem_we ? memWb.readData : dmem.dmem_rdata;
                    end else begin
                        memWb.valid <= 1'b0;
                        oErr        <= timeoutHit;
                    end
                end
                default: memWb.valid <= 1'b0;
            endcase
        end
    end

    assign oValid    = memWb.valid;
    assign oRegWrite = memWb.regWrite;
    assign oMemToReg = memWb.memToReg;
    assign oReadData = memWb.readData;
    assign oResult   = memWb.result;
    assign oPC       = memWb.pc;
    assign oIR       = memWb.ir;
    assign oRegDest  = memWb.regDest;

endmodule
